// File: rtl/decode_status_scan.sv
// decode_status_scan: time-multiplexed status display driver for the valve
// channels. Scans N_CH channels onto a shared active-low seven-segment bus
// with active-low digit selects. Each digit shows "A" (open), "F" (closed)
// or "E" (error). Every slot opens with a dark anti-ghosting gap.
// Optional feature macro: ERROR_BLINK_EN. When defined, error digits blink
// (blank for BLINK_DIV frames, "E" for BLINK_DIV frames). When undefined,
// error digits show a steady "E".
module decode_status_scan #(
   parameter int N_CH      = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16,
   parameter int BLINK_DIV = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            enable_i,
   input  logic [N_CH-1:0] ve_i,
   input  logic [N_CH-1:0] erro_i,
   output logic            seg_a_o,
   output logic            seg_b_o,
   output logic            seg_c_o,
   output logic            seg_d_o,
   output logic            seg_e_o,
   output logic            seg_f_o,
   output logic            seg_g_o,
   output logic            seg_p_o,
   output logic [N_CH-1:0] dig_o,
   output logic            frame_o,
   output logic [1:0]      state_o
);

   localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0]   SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CHW-1:0]  CH_LAST    = CHW'(N_CH - 1);
   localparam logic [N_CH-1:0] DIG_ONE    = N_CH'(1);

   // Glyphs packed as {A,B,C,D,E,F,G}, active low.
   localparam logic [6:0] GLYPH_OPEN   = 7'b0001000;
   localparam logic [6:0] GLYPH_CLOSED = 7'b0111000;
   localparam logic [6:0] GLYPH_ERROR  = 7'b0110000;
   localparam logic [6:0] GLYPH_BLANK  = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CHW-1:0]    ch_q, ch_d;
   logic              hold_err_q, hold_err_d;
   logic              hold_open_q, hold_open_d;
   logic [6:0]        seg_q, seg_d;
   logic              seg_p_q, seg_p_d;
   logic [N_CH-1:0]   dig_q, dig_d;
   logic              frame_q, frame_d;
   logic              wrap;
   logic              blank_err;

   assign state_o = state_q;

   // Scan FSM next state: slot counter, channel advance and glyph sampling.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ch_d        = ch_q;
      hold_err_d  = hold_err_q;
      hold_open_d = hold_open_q;
      wrap        = 1'b0;
      if (!enable_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         ch_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               ch_d    = '0;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == BLANK_LAST) begin
                  // Sample once so the glyph cannot change within the slot.
                  state_d     = ST_DRIVE;
                  hold_err_d  = erro_i[ch_q];
                  hold_open_d = ve_i[ch_q];
               end
            end
            ST_DRIVE: begin
               if (cnt_q == SLOT_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
                  if (ch_q == CH_LAST) begin
                     ch_d = '0;
                     wrap = 1'b1;
                  end else begin
                     ch_d = ch_q + CHW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               ch_d    = '0;
            end
         endcase
      end
   end

   // Scan FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ch_q        <= '0;
         hold_err_q  <= 1'b0;
         hold_open_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ch_q        <= ch_d;
         hold_err_q  <= hold_err_d;
         hold_open_q <= hold_open_d;
      end
   end

`ifdef ERROR_BLINK_EN
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_DIV - 1);

   logic          phase_q, phase_d;
   logic [FW-1:0] fcnt_q, fcnt_d;

   // Blink phase flips after every BLINK_DIV frame wraps; held while disabled.
   always_comb begin
      phase_d = phase_q;
      fcnt_d  = fcnt_q;
      if (wrap) begin
         if (fcnt_q == FCNT_LAST) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
   end

   // Blink phase and frame counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_q <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         phase_q <= phase_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign blank_err = phase_q;
`else
   // Steady "E": a legal BLINK_DIV is >= 1, so this is constant 0.
   assign blank_err = (BLINK_DIV < 1);
`endif

   // Pin values for the next cycle, derived from the current scan state.
   always_comb begin
      seg_d   = GLYPH_BLANK;
      seg_p_d = 1'b1;
      dig_d   = '1;
      frame_d = wrap;
      if (enable_i && (state_q == ST_DRIVE)) begin
         dig_d = ~(DIG_ONE << ch_q);
         if (hold_err_q) begin
            seg_d = blank_err ? GLYPH_BLANK : GLYPH_ERROR;
         end else if (hold_open_q) begin
            seg_d = GLYPH_OPEN;
         end else begin
            seg_d = GLYPH_CLOSED;
         end
         // Decimal point tracks the live error bus, not the held sample.
         if ((ch_q == '0) && (|erro_i)) begin
            seg_p_d = 1'b0;
         end
      end
   end

   // Registered pins: no combinational path from inputs to the display.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         seg_q   <= GLYPH_BLANK;
         seg_p_q <= 1'b1;
         dig_q   <= '1;
         frame_q <= 1'b0;
      end else begin
         seg_q   <= seg_d;
         seg_p_q <= seg_p_d;
         dig_q   <= dig_d;
         frame_q <= frame_d;
      end
   end

   assign {seg_a_o, seg_b_o, seg_c_o, seg_d_o, seg_e_o, seg_f_o, seg_g_o} = seg_q;
   assign seg_p_o = seg_p_q;
   assign dig_o   = dig_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_decode_status_scan.sv
// tb_decode_status_scan: directed checks of the scanned status display with
// N_CH=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=2. Expectations follow the
// ERROR_BLINK_EN build setting.
module tb_decode_status_scan;

   localparam int N_CH      = 4;
   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;
   localparam int BLINK_DIV = 2;

   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GF = 7'b0111000;
   localparam logic [6:0] GE = 7'b0110000;
   localparam logic [6:0] GB = 7'b1111111;
   localparam logic [12:0] DARK = {4'hf, 7'h7f, 1'b1, 1'b0};

   typedef struct {
      logic [3:0]  ve;
      logic [3:0]  erro;
      logic [27:0] glyphs;   // channel k glyph at [7k+6:7k]
   } vec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [N_CH-1:0] ve;
   logic [N_CH-1:0] erro;
   logic            seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_p;
   logic [N_CH-1:0] dig;
   logic            frame;
   logic [1:0]      state;

   int n_checks = 0;
   int n_pass   = 0;

   vec_t vecs[5];

   decode_status_scan #(
      .N_CH(N_CH), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_DIV(BLINK_DIV)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .ve_i(ve), .erro_i(erro),
      .seg_a_o(seg_a), .seg_b_o(seg_b), .seg_c_o(seg_c), .seg_d_o(seg_d),
      .seg_e_o(seg_e), .seg_f_o(seg_f), .seg_g_o(seg_g), .seg_p_o(seg_p),
      .dig_o(dig), .frame_o(frame), .state_o(state)
   );

   // Clock
   always #5 clk = ~clk;

   // Pins packed as {dig, A..G, P, frame}.
   function automatic logic [12:0] pins();
      return {dig, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_p, frame};
   endfunction

   // Expected pins n cycles after Enable was first seen high (n counted in
   // negedges from the enable/reset-release negedge).
   function automatic logic [12:0] exp_pins(input int n, input logic [27:0] g,
                                            input logic [3:0] blink_mask,
                                            input logic err_any);
      logic [3:0] d   = 4'hf;
      logic [6:0] s   = GB;
      logic       p   = 1'b1;
      logic       fr  = 1'b0;
      logic [3:0] one = 4'b0001;
      int m, f, k, w;
      if (n >= 4) begin
         m = n - 4;
         f = m / 32;
         k = (m % 32) / 8;
         w = m % 8;
         if (w < 6) begin
            d = ~(one << k);
            s = g[7*k +: 7];
`ifdef ERROR_BLINK_EN
            if (blink_mask[k] && (((f / 2) % 2) == 1)) s = GB;
`else
            if (blink_mask[k] && (f < 0)) s = GB;
`endif
            if ((k == 0) && err_any) p = 1'b0;
         end
      end
      if ((n >= 33) && (((n - 33) % 32) == 0)) fr = 1'b1;
      return {d, s, p, fr};
   endfunction

   task automatic check(input string name, input int n, input logic [12:0] act,
                        input logic [12:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s n=%0d got dig=%b seg=%b p=%b fr=%b want dig=%b seg=%b p=%b fr=%b",
                    name, n, act[12:9], act[8:2], act[1], act[0],
                    exp[12:9], exp[8:2], exp[1], exp[0]);
   endtask

   task automatic step_check(input string name, input int n, input logic [27:0] g,
                             input logic [3:0] blink_mask, input logic err_any);
      @(negedge clk);
      check(name, n, pins(), exp_pins(n, g, blink_mask, err_any));
   endtask

   // Reset, then release with Enable high at a negedge (that negedge is n=0).
   task automatic do_reset(input logic [3:0] v, input logic [3:0] e);
      @(negedge clk);
      rst = 1'b1; enable = 1'b0; ve = v; erro = e;
      repeat (2) @(negedge clk);
      rst = 1'b0; enable = 1'b1;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; ve = '0; erro = '0;
      vecs[0] = '{4'b0101, 4'b0000, {GF, GA, GF, GA}};
      vecs[1] = '{4'b0000, 4'b0000, {GF, GF, GF, GF}};
      vecs[2] = '{4'b1111, 4'b0010, {GA, GA, GE, GA}};
      vecs[3] = '{4'b1010, 4'b1001, {GE, GF, GA, GE}};
      vecs[4] = '{4'b0110, 4'b0100, {GF, GE, GA, GF}};

      // Reset values
      #3;
      check("reset_pins", 0, pins(), DARK);
      check("reset_state", 0, {11'd0, state}, 13'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("idle_dark", i, pins(), DARK);
      end

      // Table: one full frame plus the start of the next per vector
      for (int i = 0; i < 5; i++) begin
         do_reset(vecs[i].ve, vecs[i].erro);
         for (int n = 1; n <= 37; n++)
            step_check($sformatf("vec%0d", i), n, vecs[i].glyphs, vecs[i].erro, |vecs[i].erro);
      end

      // Error blink over five frames on channel 1
      do_reset(4'b1111, 4'b0010);
      for (int n = 1; n <= 168; n++)
         step_check("blink", n, {GA, GA, GE, GA}, 4'b0010, 1'b1);

      // Ve[2] toggled mid-DRIVE of channel 2: visible only next frame
      do_reset(4'b0101, 4'b0000);
      for (int n = 1; n <= 60; n++) begin
         step_check("ve_toggle", n, (n < 36) ? {GF, GA, GF, GA} : {GF, GF, GF, GA},
                    4'b0000, 1'b0);
         if (n == 22) ve = 4'b0001;
      end

      // Enable dropped mid-DRIVE of channel 3, then raised again
      do_reset(4'b0101, 4'b0000);
      for (int n = 1; n <= 30; n++)
         step_check("pre_en_low", n, {GF, GA, GF, GA}, 4'b0000, 1'b0);
      enable = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         check("en_low_dark", i, pins(), DARK);
      end
      enable = 1'b1;
      for (int n = 1; n <= 14; n++)
         step_check("en_restart", n, {GF, GA, GF, GA}, 4'b0000, 1'b0);

      // Reset pulse between edges during DRIVE of channel 1
      do_reset(4'b0101, 4'b0000);
      for (int n = 1; n <= 14; n++)
         step_check("pre_rst", n, {GF, GA, GF, GA}, 4'b0000, 1'b0);
      #2 rst = 1'b1;
      #1 check("async_rst", 0, pins(), DARK);
      @(negedge clk);
      check("rst_held", 0, pins(), DARK);
      rst = 1'b0;
      for (int n = 1; n <= 14; n++)
         step_check("rst_restart", n, {GF, GA, GF, GA}, 4'b0000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
